// File: rtl/mux_output_deserializer.sv
// Packs 1-bit multiplexer samples LSB-first into WIDTH-bit words with an X/Z mask and a 2-entry valid/ready buffer.
// Optional X/Z sample counter port x_count is enabled by defining MUX_DESER_XCOUNT_EN.
module mux_output_deserializer #(
    parameter int WIDTH  = 8,
    parameter int XCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic              mux,
    input  logic              clear,
    output logic [WIDTH-1:0]  out_data,
    output logic [WIDTH-1:0]  out_xmask,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
`ifdef MUX_DESER_XCOUNT_EN
    ,
    output logic [XCNT_W-1:0] x_count
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pdata_q, pdata_d, pmask_q, pmask_d;
    logic [WIDTH-1:0] hd_data_q, hd_data_d, hd_mask_q, hd_mask_d;
    logic [WIDTH-1:0] tl_data_q, tl_data_d, tl_mask_q, tl_mask_d;
    logic             hd_vld_q, hd_vld_d, tl_vld_q, tl_vld_d;
    logic             ovf_q, ovf_d;

    logic             take, s_one, s_x, last, push, pop;
    logic [WIDTH-1:0] wdata, wmask;

    always_comb begin
        take  = sample_en && !clear;
        // 4-state compare so that X and Z samples are flagged rather than folded into 0/1
        s_one = (mux === 1'b1);
        s_x   = (mux !== 1'b0) && (mux !== 1'b1);
        wdata = pdata_q;
        wmask = pmask_q;
        wdata[cnt_q] = s_one;
        wmask[cnt_q] = s_x;
        last  = (cnt_q == CNT_W'(WIDTH - 1));
        push  = take && last;
        pop   = hd_vld_q && out_ready;

        cnt_d   = cnt_q;
        pdata_d = pdata_q;
        pmask_d = pmask_q;
        ovf_d   = ovf_q;
        if (clear) begin
            cnt_d   = '0;
            pdata_d = '0;
            pmask_d = '0;
            ovf_d   = 1'b0;
        end else if (take) begin
            if (last) begin
                cnt_d   = '0;
                pdata_d = '0;
                pmask_d = '0;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                pdata_d = wdata;
                pmask_d = wmask;
            end
        end

        hd_data_d = hd_data_q;
        hd_mask_d = hd_mask_q;
        hd_vld_d  = hd_vld_q;
        tl_data_d = tl_data_q;
        tl_mask_d = tl_mask_q;
        tl_vld_d  = tl_vld_q;
        // On a pop with an empty tail the head keeps its data and only drops valid
        if (pop) begin
            if (tl_vld_q) begin
                hd_data_d = tl_data_q;
                hd_mask_d = tl_mask_q;
                hd_vld_d  = 1'b1;
                tl_vld_d  = push;
                if (push) begin
                    tl_data_d = wdata;
                    tl_mask_d = wmask;
                end
            end else begin
                hd_vld_d = push;
                if (push) begin
                    hd_data_d = wdata;
                    hd_mask_d = wmask;
                end
            end
        end else if (push) begin
            if (!hd_vld_q) begin
                hd_data_d = wdata;
                hd_mask_d = wmask;
                hd_vld_d  = 1'b1;
            end else if (!tl_vld_q) begin
                tl_data_d = wdata;
                tl_mask_d = wmask;
                tl_vld_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pdata_q   <= '0;
            pmask_q   <= '0;
            hd_data_q <= '0;
            hd_mask_q <= '0;
            hd_vld_q  <= 1'b0;
            tl_data_q <= '0;
            tl_mask_q <= '0;
            tl_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pdata_q   <= pdata_d;
            pmask_q   <= pmask_d;
            hd_data_q <= hd_data_d;
            hd_mask_q <= hd_mask_d;
            hd_vld_q  <= hd_vld_d;
            tl_data_q <= tl_data_d;
            tl_mask_q <= tl_mask_d;
            tl_vld_q  <= tl_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_data  = hd_data_q;
    assign out_xmask = hd_mask_q;
    assign out_valid = hd_vld_q;
    assign overflow  = ovf_q;

`ifdef MUX_DESER_XCOUNT_EN
    logic [XCNT_W-1:0] xcnt_q, xcnt_d;

    always_comb begin
        xcnt_d = xcnt_q;
        if (clear) begin
            xcnt_d = '0;
        end else if (take && s_x && (xcnt_q != {XCNT_W{1'b1}})) begin
            xcnt_d = xcnt_q + XCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xcnt_q <= '0;
        end else begin
            xcnt_q <= xcnt_d;
        end
    end

    assign x_count = xcnt_q;
`endif

endmodule

// File: tb/tb_mux_output_deserializer.sv
// Directed and randomized bench for mux_output_deserializer (WIDTH=8) against a queue-based reference model.
// Honours MUX_DESER_XCOUNT_EN to also check x_count.
module tb_mux_output_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic       mux = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data, out_xmask;
    logic       out_valid, overflow;
`ifdef MUX_DESER_XCOUNT_EN
    logic [7:0] x_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: partial word, word queue, sticky overflow, X count
    int         nb = 0;
    int         pd = 0;
    int         pm = 0;
    logic [7:0] mq_d[$];
    logic [7:0] mq_m[$];
    bit         movf = 1'b0;
    int         mxc = 0;

    mux_output_deserializer #(.WIDTH(8), .XCNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .mux       (mux),
        .clear     (clear),
        .out_data  (out_data),
        .out_xmask (out_xmask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
`ifdef MUX_DESER_XCOUNT_EN
        ,
        .x_count   (x_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        nb = 0; pd = 0; pm = 0; movf = 1'b0; mxc = 0;
        mq_d.delete();
        mq_m.delete();
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, (mq_d.size() != 0)});
        if (mq_d.size() != 0) begin
            chk({tag, "_data"}, {24'd0, out_data}, {24'd0, mq_d[0]});
            chk({tag, "_mask"}, {24'd0, out_xmask}, {24'd0, mq_m[0]});
        end
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, movf});
`ifdef MUX_DESER_XCOUNT_EN
        chk({tag, "_xcnt"}, {24'd0, x_count}, mxc);
`endif
    endtask

    // One clock: drive inputs, advance the model by the same edge, then compare
    task automatic step(input logic en, input logic m, input logic clr, input logic rdy,
                        input string tag);
        sample_en = en; mux = m; clear = clr; out_ready = rdy;
        @(posedge clk);
        if (rdy && mq_d.size() != 0) begin
            void'(mq_d.pop_front());
            void'(mq_m.pop_front());
        end
        if (clr) begin
            nb = 0; pd = 0; pm = 0; movf = 1'b0; mxc = 0;
        end else if (en) begin
            if (m === 1'b1) pd = pd + (1 << nb);
            else if (m !== 1'b0) begin
                pm = pm + (1 << nb);
                if (mxc < 255) mxc++;
            end
            nb++;
            if (nb == 8) begin
                if (mq_d.size() < 2) begin
                    mq_d.push_back(8'(pd));
                    mq_m.push_back(8'(pm));
                end else begin
                    movf = 1'b1;
                end
                nb = 0; pd = 0; pm = 0;
            end
        end
        #1;
        check_model(tag);
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy_body, input logic rdy_last,
                             input string tag);
        for (int i = 0; i < 8; i++)
            step(1'b1, w[i], 1'b0, (i == 7) ? rdy_last : rdy_body, tag);
    endtask

    task automatic idle(input int n, input logic rdy, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, tag);
    endtask

    initial begin
        logic [7:0] t2;
        logic       probe;
        logic       r_m;
        int         r;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_mask", {24'd0, out_xmask}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Test 1: 1,0,1,1,0,0,0,1 -> 8'h8D
        send_word(8'h8D, 1'b1, 1'b1, "t1");
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {24'd0, out_data}, 32'h8D);
        chk("t1_mask", {24'd0, out_xmask}, 32'h00);
        idle(2, 1'b1, "t1_drain");

        // Test 2: 1,1,x,0,z,0,0,0 -> data 03, mask 14
        t2 = 8'b000z0x11;
        for (int i = 0; i < 8; i++) step(1'b1, t2[i], 1'b0, 1'b0, "t2");
        probe = 1'bx;
        if (probe !== 1'b0 && probe !== 1'b1) begin
            chk("t2_data", {24'd0, out_data}, 32'h03);
            chk("t2_mask", {24'd0, out_xmask}, 32'h14);
`ifdef MUX_DESER_XCOUNT_EN
            chk("t2_xcnt", {24'd0, x_count}, 32'd2);
`endif
        end
        idle(2, 1'b1, "t2_drain");

        // Test 3: overflow on the third word, then drain A5, 3C
        send_word(8'hA5, 1'b0, 1'b0, "t3");
        send_word(8'h3C, 1'b0, 1'b0, "t3");
        send_word(8'hFF, 1'b0, 1'b0, "t3");
        chk("t3_ovf", {31'd0, overflow}, 32'd1);
        chk("t3_head0", {24'd0, out_data}, 32'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t3_pop");
        chk("t3_head1", {24'd0, out_data}, 32'h3C);
        chk("t3_valid1", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t3_pop");
        chk("t3_empty", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "t3_clr");

        // Test 4: push and pop on the same edge while full
        send_word(8'h11, 1'b0, 1'b0, "t4");
        send_word(8'h22, 1'b0, 1'b0, "t4");
        send_word(8'h33, 1'b0, 1'b1, "t4");
        chk("t4_ovf", {31'd0, overflow}, 32'd0);
        chk("t4_head0", {24'd0, out_data}, 32'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t4_pop");
        chk("t4_head1", {24'd0, out_data}, 32'h33);
        step(1'b0, 1'b0, 1'b0, 1'b1, "t4_pop");
        chk("t4_empty", {31'd0, out_valid}, 32'd0);

        // Test 5: asynchronous reset mid-word with a word buffered
        send_word(8'h5A, 1'b0, 1'b0, "t5");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t5");
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_data", {24'd0, out_data}, 32'd0);
        chk("t5_rst_mask", {24'd0, out_xmask}, 32'd0);
        chk("t5_rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef MUX_DESER_XCOUNT_EN
        chk("t5_rst_xcnt", {24'd0, x_count}, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(8'hFF, 1'b0, 1'b0, "t5");
        chk("t5_data", {24'd0, out_data}, 32'hFF);
        idle(1, 1'b1, "t5_drain");

        // Test 6: clear mid-word keeps the buffer and drops partial bits and overflow
        send_word(8'h01, 1'b0, 1'b0, "t6");
        send_word(8'h02, 1'b0, 1'b0, "t6");
        send_word(8'h03, 1'b0, 1'b0, "t6");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, "t6");
        step(1'b1, 1'b1, 1'b1, 1'b0, "t6_clr");
        chk("t6_ovf", {31'd0, overflow}, 32'd0);
        chk("t6_keep", {24'd0, out_data}, 32'h01);
        idle(2, 1'b1, "t6_drain");
        send_word(8'h96, 1'b1, 1'b1, "t6");
        chk("t6_data", {24'd0, out_data}, 32'h96);
        chk("t6_mask", {24'd0, out_xmask}, 32'h00);
        idle(1, 1'b1, "t6_drain");

        // Randomized traffic with occasional X samples, clears and back-pressure
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 15);
            r_m = (r == 0) ? 1'bx : r[0];
            step(($urandom_range(0, 3) != 0), r_m, ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0), "rnd");
        end
        idle(3, 1'b1, "end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
